calc_seq_engine: RTL

Parametrised, multi-cycle arithmetic engine for the switch/button calculator.
- Operands are A = sw[W-1:0] and B = sw[2W-1:W].
- The selected operation is chosen by a mode button that steps through eight operations.
- The engine recomputes automatically whenever the operands or the operation change.
- It replaces the free-running per-operator instances with one iterative datapath, and adds handshake, overflow and divide-by-zero status.
- Its result feeds the existing binary-to-BCD / seven-segment path.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_seq_engine_btn_edge.sv | 63 ++++++
 rtl/calc_seq_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator engine: operation codes and FSM states.
// Optional feature macro used by the engine: CALC_BTN_DEBOUNCE_EN.
package calc_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      DIV  = 3'd2,
      MUL  = 3'd3,
      REM  = 3'd4,
      SQRT = 3'd5,
      POW  = 3'd6,
      ONES = 3'd7
   } calc_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } calc_state_t;

   localparam int CALC_OP_COUNT = 8;

   // The op field is exactly log2(CALC_OP_COUNT) bits, so the wrap is free.
   function automatic calc_op_t next_op(calc_op_t o);
      logic [2:0] n;
      n = o + 3'd1;
      return calc_op_t'(n);
   endfunction

endpackage

// File: rtl/calc_seq_engine_btn_edge.sv
// Button conditioner: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Debounce is compiled in only when CALC_BTN_DEBOUNCE_EN is defined.
module btn_edge #(
   parameter int DB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic [1:0] sync;
   logic       level;
   logic       prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], btn};
      end
   end

`ifdef CALC_BTN_DEBOUNCE_EN
   localparam int DW = $clog2(DB_CYCLES + 1);

   logic [DW-1:0] cnt;
   logic          db;

   // The level only moves after DB_CYCLES consecutive cycles of disagreement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (sync[1] == db) begin
         cnt <= '0;
      end else if (cnt == DW'(DB_CYCLES - 1)) begin
         db  <= sync[1];
         cnt <= '0;
      end else begin
         cnt <= cnt + DW'(1);
      end
   end

   assign level = db;
`else
   logic unused_db;

   assign unused_db = (DB_CYCLES > 0);
   assign level     = sync[1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 1'b0;
      end else begin
         prev <= level;
      end
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/calc_seq_engine.sv
// Iterative calculator engine: one shared datapath for all eight operations.
// Build option: CALC_BTN_DEBOUNCE_EN enables debounce on the mode button.
import calc_pkg::*;

module calc_seq_engine #(
   parameter int W         = 4,
   parameter int DB_CYCLES = 250000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2*W-1:0] sw,
   input  logic          btn_mode,
   output logic [2:0]    op,
   output logic [2*W-1:0] result,
   output logic          busy,
   output logic          valid,
   output logic          ovf,
   output logic          dbz
);

   localparam int RW = 2 * W;
   localparam int CW = W + 1;

   calc_state_t   state, state_n;
   calc_op_t      cur_op, snap_op;
   logic [RW-1:0] snap_sw;
   logic [CW-1:0] cnt, cnt_n;
   logic [RW-1:0] x, y, z;
   logic [RW-1:0] x_n, y_n, z_n;
   logic [RW-1:0] pres, pres_n;
   logic          pov, pov_n;
   logic          pdz, pdz_n;
   logic          start, fin;
   logic          mode_pulse;

   logic [W-1:0]    sa, sb, a_in, b_in;
   logic [RW-1:0]   msum;
   logic [W:0]      dtri, drem;
   logic            dge;
   logic [RW-1:0]   srad, strial;
   logic            sge;
   logic [RW+W-1:0] prod;

   btn_edge #(
      .DB_CYCLES(DB_CYCLES)
   ) u_mode (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_mode),
      .pulse(mode_pulse)
   );

   assign op   = cur_op;
   assign sa   = snap_sw[W-1:0];
   assign sb   = snap_sw[RW-1:W];
   assign a_in = sw[W-1:0];
   assign b_in = sw[RW-1:W];

   // Register roles per op: MUL x=acc y=multiplicand z=multiplier;
   // DIV/REM x=remainder z=dividend/quotient; SQRT x=rem y=root z=radicand.
   assign msum   = z[0] ? x + y : x;
   assign dtri   = {x[W-1:0], z[W-1]};
   assign dge    = dtri >= {1'b0, sb};
   assign drem   = dge ? dtri - {1'b0, sb} : dtri;
   assign srad   = {x[RW-3:0], z[RW-1:RW-2]};
   assign strial = {y[RW-3:0], 2'b01};
   assign sge    = srad >= strial;
   assign prod   = {{W{1'b0}}, x} * {{RW{1'b0}}, sa};

   always_comb begin
      state_n = state;
      start   = 1'b0;
      fin     = 1'b0;
      x_n     = x;
      y_n     = y;
      z_n     = z;
      cnt_n   = cnt;
      pres_n  = pres;
      pov_n   = pov;
      pdz_n   = pdz;
      unique case (state)
         IDLE: begin
            if (!valid || {cur_op, sw} != {snap_op, snap_sw}) begin
               start   = 1'b1;
               state_n = CALC;
               x_n     = (cur_op == POW) ? RW'(1) : '0;
               y_n     = (cur_op == MUL) ? {{W{1'b0}}, b_in} : '0;
               z_n     = (cur_op == SQRT) ? sw : {{W{1'b0}}, a_in};
               cnt_n   = (cur_op == POW) ? {1'b0, b_in} : CW'(W);
               pres_n  = '0;
               pov_n   = 1'b0;
               pdz_n   = 1'b0;
            end
         end
         CALC: begin
            cnt_n = cnt - CW'(1);
            unique case (1'b1)
               (snap_op == ADD): begin
                  pres_n = {{W{1'b0}}, sa} + {{W{1'b0}}, sb};
                  fin    = 1'b1;
               end
               (snap_op == SUB): begin
                  pres_n = {{W{1'b0}}, sa} - {{W{1'b0}}, sb};
                  fin    = 1'b1;
               end
               (snap_op == ONES): begin
                  pres_n = '1;
                  fin    = 1'b1;
               end
               (snap_op == MUL): begin
                  x_n = msum;
                  y_n = {y[RW-2:0], 1'b0};
                  z_n = {1'b0, z[RW-1:1]};
                  if (cnt == CW'(1)) begin
                     pres_n = msum;
                     fin    = 1'b1;
                  end
               end
               (snap_op == DIV || snap_op == REM): begin
                  if (sb == '0) begin
                     pres_n = '1;
                     pdz_n  = 1'b1;
                     fin    = 1'b1;
                  end else begin
                     x_n = {{(RW-W-1){1'b0}}, drem};
                     z_n = {z[RW-1:W], z[W-2:0], dge};
                     if (cnt == CW'(1)) begin
                        pres_n = (snap_op == DIV)
                               ? {{W{1'b0}}, z[W-2:0], dge}
                               : {{W{1'b0}}, drem[W-1:0]};
                        fin    = 1'b1;
                     end
                  end
               end
               (snap_op == SQRT): begin
                  x_n = sge ? srad - strial : srad;
                  y_n = {y[RW-2:0], sge};
                  z_n = {z[RW-3:0], 2'b00};
                  if (cnt == CW'(1)) begin
                     pres_n = {y[RW-2:0], sge};
                     fin    = 1'b1;
                  end
               end
               (snap_op == POW): begin
                  if (sb == '0) begin
                     pres_n = RW'(1);
                     fin    = 1'b1;
                  end else if (prod[RW+W-1:RW] != '0) begin
                     // Saturate and stop as soon as a partial product overflows.
                     pres_n = '1;
                     pov_n  = 1'b1;
                     fin    = 1'b1;
                  end else begin
                     x_n = prod[RW-1:0];
                     if (cnt == CW'(1)) begin
                        pres_n = prod[RW-1:0];
                        fin    = 1'b1;
                     end
                  end
               end
               default: fin = 1'b1;
            endcase
            if (fin) begin
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_op  <= ADD;
         snap_op <= ADD;
         snap_sw <= '0;
         cnt     <= '0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         pres    <= '0;
         pov     <= 1'b0;
         pdz     <= 1'b0;
         result  <= '0;
         busy    <= 1'b0;
         valid   <= 1'b0;
         ovf     <= 1'b0;
         dbz     <= 1'b0;
      end else begin
         cnt  <= cnt_n;
         x    <= x_n;
         y    <= y_n;
         z    <= z_n;
         pres <= pres_n;
         pov  <= pov_n;
         pdz  <= pdz_n;
         if (mode_pulse) begin
            cur_op <= next_op(cur_op);
         end
         if (start) begin
            snap_op <= cur_op;
            snap_sw <= sw;
            valid   <= 1'b0;
            busy    <= 1'b1;
         end
         if (state == DONE) begin
            result <= pres;
            ovf    <= pov;
            dbz    <= pdz;
            valid  <= 1'b1;
            busy   <= 1'b0;
         end
      end
   end

endmodule
